// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: shared types, widths and line helpers for the data cache controller
package dcache_ctrl_pkg;

    localparam int OFF_W     = 4;
    localparam int WORD_W    = 32;
    localparam int LINE_BITS = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        RF_REQ,
        RF_WAIT,
        FILL
    } state_t;

    function automatic logic [WORD_W-1:0] get_word(
        input logic [LINE_BITS-1:0] line,
        input logic [1:0]           sel
    );
        return line[{sel, 5'b0} +: WORD_W];
    endfunction

    function automatic logic [LINE_BITS-1:0] merge_word(
        input logic [LINE_BITS-1:0] line,
        input logic [1:0]           sel,
        input logic [WORD_W-1:0]    wdata,
        input logic [3:0]           wstrb
    );
        logic [LINE_BITS-1:0] r;
        r = line;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) r[{sel, 5'b0} + 7'(b * 8) +: 8] = wdata[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// dcache_line_ram: single-port line RAM with registered read data and full-line write
module dcache_line_ram #(
    parameter int AW = 8,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    // read data only changes on an explicit read, so it holds the victim line through eviction
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache controller
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int LINE_W  = LINE_BITS,
    parameter int ADDR_W  = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [LINE_W-1:0] mem_wr_data,
    input  logic              mem_wr_fin,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [LINE_W-1:0] mem_rd_data,
    input  logic              mem_rd_fin
);

    localparam int TAG_W = ADDR_W - OFF_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    state_t state, state_n;
    logic [ADDR_W-1:2]  addr_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [TAG_W-1:0]   tags [LINES];
    logic [LINES-1:0]   valid, dirty;
    logic [LINE_W-1:0]  rf_line, ram_rdata, ram_wdata, line_src;
    logic               ram_re, ram_we;
    logic [INDEX_W-1:0] ram_addr, idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         sel;
    logic               hit, respond;
    logic               unused_ok;

    assign unused_ok = ^req_addr[1:0];
    assign idx       = addr_q[OFF_W+INDEX_W-1:OFF_W];
    assign tag       = addr_q[ADDR_W-1:OFF_W+INDEX_W];
    assign sel       = addr_q[3:2];
    assign hit       = valid[idx] && tags[idx] == tag;
    assign respond   = (state == LOOKUP && hit) || state == FILL;
    assign line_src  = state == FILL ? rf_line : ram_rdata;
    assign ram_wdata = we_q ? merge_word(line_src, sel, wdata_q, wstrb_q) : line_src;

    dcache_line_ram #(.AW(INDEX_W), .DW(LINE_W)) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // next state, memory handshake outputs and RAM control; reset forces everything quiet
    always_comb begin
        state_n     = state;
        req_ready   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = idx;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                ram_re    = req_valid;
                ram_addr  = req_addr[OFF_W+INDEX_W-1:OFF_W];
                state_n   = req_valid ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                ram_we  = hit && we_q;
                state_n = hit ? IDLE : (valid[idx] && dirty[idx]) ? WB_REQ : RF_REQ;
            end
            WB_REQ: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = {tags[idx], idx, {OFF_W{1'b0}}};
                mem_wr_data = ram_rdata;
                state_n     = WB_WAIT;
            end
            WB_WAIT: state_n = mem_wr_fin ? RF_REQ : WB_WAIT;
            RF_REQ: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = {tag, idx, {OFF_W{1'b0}}};
                state_n     = RF_WAIT;
            end
            RF_WAIT: state_n = mem_rd_fin ? FILL : RF_WAIT;
            FILL: begin
                ram_we  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            req_ready   = 1'b0;
            mem_wr_en   = 1'b0;
            mem_wr_addr = '0;
            mem_wr_data = '0;
            mem_rd_en   = 1'b0;
            mem_rd_addr = '0;
            ram_re      = 1'b0;
            ram_we      = 1'b0;
        end
    end

    // state, line status bits and the registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= respond;
            if (respond) resp_rdata <= get_word(line_src, sel);
            if (state == LOOKUP && hit && we_q) dirty[idx] <= 1'b1;
            if (state == FILL) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= we_q;
            end
        end
    end

    // request latch, refill capture and tag update; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            addr_q  <= req_addr[ADDR_W-1:2];
            we_q    <= req_we;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
        if (state == RF_WAIT && mem_rd_fin) rf_line <= mem_rd_data;
        if (state == FILL) tags[idx] <= tag;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench with a byte-level reference memory and a latency-randomised memory model
module tb_dcache_ctrl;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [26:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_wstrb = '0;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_wr_en;
    logic [26:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic         mem_wr_fin = 1'b0;
    logic         mem_rd_en;
    logic [26:0]  mem_rd_addr;
    logic [127:0] mem_rd_data = '0;
    logic         mem_rd_fin = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];
    logic [7:0]   ref_b [int];
    logic [127:0] mem_l [int];

    int wr_n = 0, rd_n = 0, wr_delay = 1, rd_delay = 1;
    int wr_pend = 0, rd_pend = 0, wr_cd = 0, rd_cd = 0, rd_la = 0;
    int wr_fin_cyc = 0, rd_en_cyc = 0, spur_req = 0, spur_done = 0;
    logic [26:0]  last_wr_addr = '0, last_rd_addr = '0;
    logic [127:0] last_wr_data = '0;

    dcache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_fin  (mem_wr_fin),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_rd_fin  (mem_rd_fin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [127:0] init_line(input int la);
        logic [127:0] l;
        if (la == 32'h100) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = (32'(la + i) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
        return l;
    endfunction

    function automatic logic [127:0] get_line(input int la);
        return mem_l.exists(la) ? mem_l[la] : init_line(la);
    endfunction

    function automatic logic [7:0] rb(input int a);
        logic [127:0] l;
        if (ref_b.exists(a)) return ref_b[a];
        l = init_line(a & ~15);
        return l[(a & 15) * 8 +: 8];
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int w;
        w = a & ~3;
        return {rb(w + 3), rb(w + 2), rb(w + 1), rb(w)};
    endfunction

    function automatic logic [127:0] ref_line(input int la);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[k*8 +: 8] = rb(la + k);
        return l;
    endfunction

    // issue one CPU op; the expected word is the reference memory before the op takes effect
    task automatic issue(input logic we, input int a, input logic [31:0] wd, input logic [3:0] ws, input int lat);
        exp_t x;
        int n;
        x.rdata = ref_word(a);
        x.lat = lat;
        if (we)
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_b[(a & ~3) + b] = wd[b*8 +: 8];
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_addr = 27'(a);
        req_wdata = wd;
        req_wstrb = ws;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {127'b0, req_ready}, 128'd1);
            req_valid = 1'b0;
            return;
        end
        x.acc = cyc + 1;
        @(posedge clk);
        exp_q.push_back(x);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
    endtask

    // response monitor: every resp_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t x;
        int l;
        if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got rdata %h required no response", resp_rdata);
            end else begin
                x = exp_q.pop_front();
                if (resp_rdata !== x.rdata) begin
                    errors++;
                    $display("FAIL resp_rdata got %h required %h", resp_rdata, x.rdata);
                end
                if (x.lat >= 0) begin
                    l = cyc + 1 - x.acc;
                    chk("resp_latency", 128'(l), 128'(x.lat));
                end
            end
        end
    end

    // memory model: stores write-backs, returns refills after programmable delays, drops all on reset
    always @(negedge clk) begin
        mem_wr_fin = 1'b0;
        mem_rd_fin = 1'b0;
        if (rst) begin
            wr_pend = 0;
            rd_pend = 0;
        end else begin
            if (wr_pend != 0) begin
                if (wr_cd == 0) begin
                    mem_wr_fin = 1'b1;
                    wr_pend = 0;
                    wr_fin_cyc = cyc;
                end else wr_cd--;
            end
            if (rd_pend != 0) begin
                if (rd_cd == 0) begin
                    mem_rd_fin = 1'b1;
                    mem_rd_data = get_line(rd_la);
                    rd_pend = 0;
                end else rd_cd--;
            end
            if (spur_req != spur_done) begin
                mem_rd_fin = 1'b1;
                mem_rd_data = {4{32'hDEADBEEF}};
                spur_done = spur_req;
            end
            if (mem_wr_en) begin
                wr_n++;
                last_wr_addr = mem_wr_addr;
                last_wr_data = mem_wr_data;
                mem_l[int'(mem_wr_addr)] = mem_wr_data;
                wr_pend = 1;
                wr_cd = wr_delay;
            end
            if (mem_rd_en) begin
                rd_n++;
                last_rd_addr = mem_rd_addr;
                chk("rd_before_wb_fin", 128'(wr_pend), 128'd0);
                rd_pend = 1;
                rd_cd = rd_delay;
                rd_la = int'(mem_rd_addr);
                rd_en_cyc = cyc;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, k, a;
        int idxs[4];
        idxs = '{8'h10, 8'h11, 8'h20, 8'hFF};

        repeat (3) @(negedge clk);
        chk("rst_ready", {127'b0, req_ready}, 128'd0);
        chk("rst_resp_valid", {127'b0, resp_valid}, 128'd0);
        chk("rst_mem_en", {126'b0, mem_wr_en, mem_rd_en}, 128'd0);
        chk("rst_mem_addr", {74'b0, mem_wr_addr, mem_rd_addr}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {127'b0, req_ready}, 128'd1);

        w0 = wr_n; r0 = rd_n;
        issue(1'b0, 'h100, 0, 0, -1);
        wait_idle();
        chk("cold_rd_cnt", 128'(rd_n - r0), 128'd1);
        chk("cold_wr_cnt", 128'(wr_n - w0), 128'd0);
        chk("cold_rd_addr", 128'(last_rd_addr), 128'h100);

        w0 = wr_n; r0 = rd_n;
        issue(1'b0, 'h104, 0, 0, 2);
        wait_idle();
        chk("hit_traffic", 128'(rd_n - r0 + wr_n - w0), 128'd0);

        issue(1'b1, 'h108, 32'h12345678, 4'b0011, 2);
        issue(1'b0, 'h108, 0, 0, 2);
        wait_idle();

        wr_delay = 20;
        w0 = wr_n; r0 = rd_n;
        issue(1'b0, 'h0100100, 0, 0, -1);
        wait_idle();
        chk("conf_wr_cnt", 128'(wr_n - w0), 128'd1);
        chk("conf_wr_addr", 128'(last_wr_addr), 128'h100);
        chk("conf_wr_data", last_wr_data, 128'hDDDDDDDD_CCCC5678_BBBBBBBB_AAAAAAAA);
        chk("conf_rd_cnt", 128'(rd_n - r0), 128'd1);
        chk("conf_rd_addr", 128'(last_rd_addr), 128'h0100100);
        chk("conf_rd_after_fin", {127'b0, rd_en_cyc > wr_fin_cyc}, 128'd1);
        wr_delay = 1;

        r0 = rd_n;
        spur_req++;
        repeat (5) @(negedge clk);
        chk("spur_idle_ready", {127'b0, req_ready}, 128'd1);
        chk("spur_no_traffic", 128'(rd_n - r0), 128'd0);

        rd_delay = 30;
        r0 = rd_n;
        issue(1'b0, 'h0200200, 0, 0, -1);
        k = 0;
        while (rd_n == r0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("abandon_rf_issued", 128'(rd_n - r0), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("midop_rst_ready", {127'b0, req_ready}, 128'd0);
        end
        rst = 1'b0;
        rd_delay = 1;
        r0 = rd_n;
        issue(1'b0, 'h100, 0, 0, -1);
        wait_idle();
        chk("post_rst_miss", 128'(rd_n - r0), 128'd1);
        chk("post_rst_rd_addr", 128'(last_rd_addr), 128'h100);

        w0 = wr_n;
        issue(1'b1, 'h200, 32'hFFFFFFFF, 4'b0000, -1);
        issue(1'b0, 'h1200, 0, 0, -1);
        wait_idle();
        chk("strb0_dirty_wb", 128'(wr_n - w0), 128'd1);
        chk("strb0_wb_addr", 128'(last_wr_addr), 128'h200);

        for (int i = 0; i < 2000; i++) begin
            wr_delay = $urandom_range(0, 3);
            rd_delay = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) << 12) | (idxs[$urandom_range(0, 3)] << 4) | $urandom_range(0, 15);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), -1);
        end
        wait_idle();

        for (int i = 0; i < 4; i++) issue(1'b0, (7 << 12) | (idxs[i] << 4), 0, 0, -1);
        wait_idle();
        for (int i = 0; i < 4; i++)
            for (int t = 0; t < 4; t++) begin
                a = (t << 12) | (idxs[i] << 4);
                chk("final_mem_line", get_line(a), ref_line(a));
            end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
